// File: rtl/qdrc_phy_wr_path.sv
`default_nettype none
// ============================================================================
// Module      : qdrc_phy_wr_path
// Description : QDR write-side PHY datapath. Turns each burst-of-4 write into
//               one W_n strobe plus two cycles of rise/fall data and byte
//               writes, and drives a fixed training burst during calibration.
// Revision    : 1.0 - initial release
// ============================================================================
module qdrc_phy_wr_path #(
    parameter int DATA_WIDTH = 18,
    parameter int BW_WIDTH   = 2,
    parameter int DATA_DELAY = 1
) (
    input  logic                    clk0,
    input  logic                    reset,
    input  logic                    wr_en,
    output logic                    wr_ready,
    input  logic [4*DATA_WIDTH-1:0] wr_data,
    input  logic [4*BW_WIDTH-1:0]   wr_be,
    input  logic                    cal_en,
    output logic                    wr_done,
    output logic                    qdr_w_n,
    output logic [DATA_WIDTH-1:0]   qdr_d_rise,
    output logic [DATA_WIDTH-1:0]   qdr_d_fall,
    output logic [BW_WIDTH-1:0]     qdr_bw_n_rise,
    output logic [BW_WIDTH-1:0]     qdr_bw_n_fall
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_CAL0 = 2'd2;
    localparam logic [1:0] c_CAL1 = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic                    r_wr_ready;
    logic                    r_w_n;
    logic [2*DATA_WIDTH-1:0] r_hi_data;   // beats 2/3 held for the second cycle
    logic [2*BW_WIDTH-1:0]   r_hi_be;

    // Values entering the head of the bus pipeline this cycle
    logic                    w_issue;
    logic [DATA_WIDTH-1:0]   w_inj_d_rise;
    logic [DATA_WIDTH-1:0]   w_inj_d_fall;
    logic [BW_WIDTH-1:0]     w_inj_bw_n_rise;
    logic [BW_WIDTH-1:0]     w_inj_bw_n_fall;
    logic                    w_inj_done;

    // Idle stages carry the idle bus values, so the last stage drives the bus directly
    logic [DATA_WIDTH-1:0]   r_pipe_d_rise    [0:DATA_DELAY];
    logic [DATA_WIDTH-1:0]   r_pipe_d_fall    [0:DATA_DELAY];
    logic [BW_WIDTH-1:0]     r_pipe_bw_n_rise [0:DATA_DELAY];
    logic [BW_WIDTH-1:0]     r_pipe_bw_n_fall [0:DATA_DELAY];
    logic                    r_pipe_done      [0:DATA_DELAY];

    // State register; wr_ready is registered from the next state so it stays low in reset
    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_wr_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wr_ready <= (w_next_state == c_IDLE);
        end
    end

    // Next-state logic; calibration wins over a simultaneous write request
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_wr_ready) begin
                    if (cal_en)
                        w_next_state = c_CAL0;
                    else if (wr_en)
                        w_next_state = c_BUSY;
                end
            end
            c_BUSY:  w_next_state = c_IDLE;
            c_CAL0:  w_next_state = c_CAL1;
            c_CAL1:  w_next_state = cal_en ? c_CAL0 : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic: first beat pair on issue, second pair the cycle after
    always_comb begin
        w_issue         = (w_next_state == c_BUSY) || (w_next_state == c_CAL0);
        w_inj_d_rise    = '0;
        w_inj_d_fall    = '0;
        w_inj_bw_n_rise = '1;
        w_inj_bw_n_fall = '1;
        w_inj_done      = 1'b0;
        if (w_next_state == c_BUSY) begin
            w_inj_d_rise    = wr_data[DATA_WIDTH-1:0];
            w_inj_d_fall    = wr_data[2*DATA_WIDTH-1:DATA_WIDTH];
            w_inj_bw_n_rise = ~wr_be[BW_WIDTH-1:0];
            w_inj_bw_n_fall = ~wr_be[2*BW_WIDTH-1:BW_WIDTH];
        end else if (w_next_state == c_CAL0) begin
            w_inj_d_rise    = '1;
            w_inj_bw_n_rise = '0;
            w_inj_bw_n_fall = '0;
        end else if (r_state == c_BUSY) begin
            w_inj_d_rise    = r_hi_data[DATA_WIDTH-1:0];
            w_inj_d_fall    = r_hi_data[2*DATA_WIDTH-1:DATA_WIDTH];
            w_inj_bw_n_rise = ~r_hi_be[BW_WIDTH-1:0];
            w_inj_bw_n_fall = ~r_hi_be[2*BW_WIDTH-1:BW_WIDTH];
            w_inj_done      = 1'b1;
        end else if (r_state == c_CAL0) begin
            w_inj_bw_n_rise = '0;
            w_inj_bw_n_fall = '0;
        end
    end

    // W_n strobe and capture of the second beat pair at accept
    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            r_w_n     <= 1'b1;
            r_hi_data <= '0;
            r_hi_be   <= '0;
        end else begin
            r_w_n <= ~w_issue;
            if (w_next_state == c_BUSY) begin
                r_hi_data <= wr_data[4*DATA_WIDTH-1:2*DATA_WIDTH];
                r_hi_be   <= wr_be[4*BW_WIDTH-1:2*BW_WIDTH];
            end
        end
    end

    // Bus pipeline: DATA_DELAY+1 stages, the last one is the output register
    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DATA_DELAY; i++) begin
                r_pipe_d_rise[i]    <= '0;
                r_pipe_d_fall[i]    <= '0;
                r_pipe_bw_n_rise[i] <= '1;
                r_pipe_bw_n_fall[i] <= '1;
                r_pipe_done[i]      <= 1'b0;
            end
        end else begin
            r_pipe_d_rise[0]    <= w_inj_d_rise;
            r_pipe_d_fall[0]    <= w_inj_d_fall;
            r_pipe_bw_n_rise[0] <= w_inj_bw_n_rise;
            r_pipe_bw_n_fall[0] <= w_inj_bw_n_fall;
            r_pipe_done[0]      <= w_inj_done;
            for (int i = 1; i <= DATA_DELAY; i++) begin
                r_pipe_d_rise[i]    <= r_pipe_d_rise[i-1];
                r_pipe_d_fall[i]    <= r_pipe_d_fall[i-1];
                r_pipe_bw_n_rise[i] <= r_pipe_bw_n_rise[i-1];
                r_pipe_bw_n_fall[i] <= r_pipe_bw_n_fall[i-1];
                r_pipe_done[i]      <= r_pipe_done[i-1];
            end
        end
    end

    assign wr_ready      = r_wr_ready;
    assign qdr_w_n       = r_w_n;
    assign qdr_d_rise    = r_pipe_d_rise[DATA_DELAY];
    assign qdr_d_fall    = r_pipe_d_fall[DATA_DELAY];
    assign qdr_bw_n_rise = r_pipe_bw_n_rise[DATA_DELAY];
    assign qdr_bw_n_fall = r_pipe_bw_n_fall[DATA_DELAY];
    assign wr_done       = r_pipe_done[DATA_DELAY];

endmodule
`default_nettype wire

// File: tb/tb_qdrc_phy_wr_path.sv
`default_nettype none
// ============================================================================
// Module      : tb_qdrc_phy_wr_path
// Description : Directed self-checking bench for qdrc_phy_wr_path
//               (DATA_DELAY=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qdrc_phy_wr_path;

    localparam int DW = 18;
    localparam int BW = 2;
    localparam int DD = 1;

    logic          clk0 = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          wr_ready;
    logic [4*DW-1:0] wr_data;
    logic [4*BW-1:0] wr_be;
    logic          cal_en;
    logic          wr_done;
    logic          qdr_w_n;
    logic [DW-1:0] qdr_d_rise;
    logic [DW-1:0] qdr_d_fall;
    logic [BW-1:0] qdr_bw_n_rise;
    logic [BW-1:0] qdr_bw_n_fall;

    int n_pass  = 0;
    int n_total = 0;

    qdrc_phy_wr_path #(
        .DATA_WIDTH (DW),
        .BW_WIDTH   (BW),
        .DATA_DELAY (DD)
    ) dut (
        .clk0          (clk0),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .cal_en        (cal_en),
        .wr_done       (wr_done),
        .qdr_w_n       (qdr_w_n),
        .qdr_d_rise    (qdr_d_rise),
        .qdr_d_fall    (qdr_d_fall),
        .qdr_bw_n_rise (qdr_bw_n_rise),
        .qdr_bw_n_fall (qdr_bw_n_fall)
    );

    always #5 clk0 = ~clk0;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; cal_en = 1'b0; wr_data = '0; wr_be = '0;
        repeat (3) tick();
        n_total++;
        if (qdr_w_n !== 1'b1 || qdr_d_rise !== 18'h0 || qdr_d_fall !== 18'h0 ||
            qdr_bw_n_rise !== 2'b11 || qdr_bw_n_fall !== 2'b11 || wr_ready !== 1'b0 || wr_done !== 1'b0)
            $display("FAIL reset_values: w_n=%b rise=%h fall=%h bwr=%b bwf=%b rdy=%b done=%b, required 1/0/0/11/11/0/0",
                     qdr_w_n, qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall, wr_ready, wr_done);
        else n_pass++;
        reset = 1'b0;
        #2;
        n_total++;
        if (wr_ready !== 1'b0) $display("FAIL ready_before_edge: got %b, required 0", wr_ready);
        else n_pass++;
        tick();
        n_total++;
        if (wr_ready !== 1'b1) $display("FAIL ready_after_release: got %b, required 1", wr_ready);
        else n_pass++;
    endtask

    task automatic test_single_write();
        wr_data = {18'h15555, 18'h2AAAA, 18'h00001, 18'h3FFFF};
        wr_be   = '1;
        wr_en   = 1'b1;
        tick();                        // accept edge T, now cycle T+1
        wr_en = 1'b0;
        n_total++;
        if (qdr_w_n !== 1'b0 || wr_ready !== 1'b0)
            $display("FAIL single_wn: w_n=%b rdy=%b, required 0/0", qdr_w_n, wr_ready);
        else n_pass++;
        tick();                        // cycle T+2
        n_total++;
        if (qdr_w_n !== 1'b1 || qdr_d_rise !== 18'h3FFFF || qdr_d_fall !== 18'h00001 ||
            qdr_bw_n_rise !== 2'b00 || qdr_bw_n_fall !== 2'b00 || wr_done !== 1'b0)
            $display("FAIL single_pair01: w_n=%b rise=%h fall=%h bwr=%b bwf=%b done=%b, required 1/3ffff/00001/00/00/0",
                     qdr_w_n, qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall, wr_done);
        else n_pass++;
        tick();                        // cycle T+3
        n_total++;
        if (qdr_d_rise !== 18'h2AAAA || qdr_d_fall !== 18'h15555 ||
            qdr_bw_n_rise !== 2'b00 || qdr_bw_n_fall !== 2'b00 || wr_done !== 1'b1)
            $display("FAIL single_pair23: rise=%h fall=%h bwr=%b bwf=%b done=%b, required 2aaaa/15555/00/00/1",
                     qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall, wr_done);
        else n_pass++;
        tick();                        // cycle T+4, idle again
        n_total++;
        if (qdr_d_rise !== 18'h0 || qdr_d_fall !== 18'h0 || qdr_bw_n_rise !== 2'b11 ||
            qdr_bw_n_fall !== 2'b11 || wr_done !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL single_idle: rise=%h fall=%h bwr=%b bwf=%b done=%b rdy=%b, required 0/0/11/11/0/1",
                     qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall, wr_done, wr_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int       n_wn;
        int       n_done;
        logic     exp_wn;
        logic     exp_done;
        logic [DW-1:0] exp_rise;
        logic [DW-1:0] exp_fall;
        n_wn = 0; n_done = 0;
        wr_be = '1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            int b;
            int c;
            b = cyc / 2;
            // beat j of burst b is b*16 + j + 1
            wr_data = {DW'(b*16+4), DW'(b*16+3), DW'(b*16+2), DW'(b*16+1)};
            wr_en   = (cyc < 6);
            tick();
            c        = cyc + 1;
            exp_wn   = !((c == 1) || (c == 3) || (c == 5));
            exp_done = (c == 3) || (c == 5) || (c == 7);
            exp_rise = '0;
            exp_fall = '0;
            if (c >= 2 && c <= 7) begin
                b = (c - 2) / 2;
                if (((c - 2) % 2) == 0) begin
                    exp_rise = DW'(b*16+1); exp_fall = DW'(b*16+2);
                end else begin
                    exp_rise = DW'(b*16+3); exp_fall = DW'(b*16+4);
                end
            end
            if (qdr_w_n == 1'b0) n_wn++;
            if (wr_done == 1'b1) n_done++;
            n_total++;
            if (qdr_w_n !== exp_wn || wr_ready !== exp_wn || wr_done !== exp_done ||
                qdr_d_rise !== exp_rise || qdr_d_fall !== exp_fall)
                $display("FAIL b2b_cycle%0d: w_n=%b rdy=%b done=%b rise=%h fall=%h, required %b/%b/%b/%h/%h",
                         c, qdr_w_n, wr_ready, wr_done, qdr_d_rise, qdr_d_fall,
                         exp_wn, exp_wn, exp_done, exp_rise, exp_fall);
            else n_pass++;
        end
        n_total++;
        if (n_wn !== 3 || n_done !== 3)
            $display("FAIL b2b_counts: w_n pulses=%0d done pulses=%0d, required 3/3", n_wn, n_done);
        else n_pass++;
    endtask

    task automatic test_byte_enables();
        wr_data = {18'h00444, 18'h00333, 18'h00222, 18'h00111};
        wr_be   = {2'b11, 2'b01, 2'b11, 2'b11};
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        n_total++;
        if (qdr_bw_n_rise !== 2'b00 || qdr_bw_n_fall !== 2'b00)
            $display("FAIL be_pair01: bwr=%b bwf=%b, required 00/00", qdr_bw_n_rise, qdr_bw_n_fall);
        else n_pass++;
        tick();
        n_total++;
        if (qdr_bw_n_rise !== 2'b10 || qdr_bw_n_fall !== 2'b00 || qdr_d_rise !== 18'h00333)
            $display("FAIL be_pair23: bwr=%b bwf=%b rise=%h, required 10/00/00333",
                     qdr_bw_n_rise, qdr_bw_n_fall, qdr_d_rise);
        else n_pass++;
        tick();
        n_total++;
        if (qdr_bw_n_rise !== 2'b11 || qdr_bw_n_fall !== 2'b11)
            $display("FAIL be_idle: bwr=%b bwf=%b, required 11/11", qdr_bw_n_rise, qdr_bw_n_fall);
        else n_pass++;
    endtask

    task automatic test_calibration();
        int n_done;
        logic          exp_wn;
        logic          exp_rdy;
        logic [DW-1:0] exp_rise;
        logic [BW-1:0] exp_bw;
        n_done  = 0;
        wr_data = {18'h12345, 18'h12345, 18'h12345, 18'h12345};
        wr_be   = '1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            int c;
            cal_en = (cyc < 7);
            wr_en  = (cyc < 7);
            tick();
            c        = cyc + 1;
            exp_wn   = !(((c % 2) == 1) && (c <= 7));
            exp_rdy  = (c >= 9);
            exp_rise = (((c % 2) == 0) && c >= 2 && c <= 8) ? '1 : '0;
            exp_bw   = (c >= 2 && c <= 9) ? 2'b00 : 2'b11;
            if (wr_done == 1'b1) n_done++;
            n_total++;
            if (qdr_w_n !== exp_wn || wr_ready !== exp_rdy || qdr_d_rise !== exp_rise ||
                qdr_d_fall !== 18'h0 || qdr_bw_n_rise !== exp_bw || qdr_bw_n_fall !== exp_bw)
                $display("FAIL cal_cycle%0d: w_n=%b rdy=%b rise=%h fall=%h bwr=%b bwf=%b, required %b/%b/%h/0/%b/%b",
                         c, qdr_w_n, wr_ready, qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall,
                         exp_wn, exp_rdy, exp_rise, exp_bw, exp_bw);
            else n_pass++;
        end
        n_total++;
        if (n_done !== 0) $display("FAIL cal_no_done: done pulses=%0d, required 0", n_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int n_done;
        n_done  = 0;
        wr_data = {18'h0DDDD, 18'h0CCCC, 18'h0BBBB, 18'h0AAAA};
        wr_be   = '1;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();                        // pair01 on the bus
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (qdr_w_n !== 1'b1 || qdr_d_rise !== 18'h0 || qdr_d_fall !== 18'h0 ||
            qdr_bw_n_rise !== 2'b11 || qdr_bw_n_fall !== 2'b11 || wr_done !== 1'b0 || wr_ready !== 1'b0)
            $display("FAIL midrst_async_idle: w_n=%b rise=%h fall=%h bwr=%b bwf=%b done=%b rdy=%b, required 1/0/0/11/11/0/0",
                     qdr_w_n, qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall, wr_done, wr_ready);
        else n_pass++;
        tick();
        if (wr_done == 1'b1) n_done++;
        reset = 1'b0;
        repeat (2) begin
            tick();
            if (wr_done == 1'b1) n_done++;
        end
        n_total++;
        if (n_done !== 0 || wr_ready !== 1'b1 || qdr_d_rise !== 18'h0)
            $display("FAIL midrst_recover: done pulses=%0d rdy=%b rise=%h, required 0/1/0",
                     n_done, wr_ready, qdr_d_rise);
        else n_pass++;
        wr_data = {18'h04444, 18'h03333, 18'h02222, 18'h01111};
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        n_total++;
        if (qdr_w_n !== 1'b0) $display("FAIL midrst_post_wn: got %b, required 0", qdr_w_n);
        else n_pass++;
        tick();
        n_total++;
        if (qdr_d_rise !== 18'h01111 || qdr_d_fall !== 18'h02222 || wr_done !== 1'b0)
            $display("FAIL midrst_post_pair01: rise=%h fall=%h done=%b, required 01111/02222/0",
                     qdr_d_rise, qdr_d_fall, wr_done);
        else n_pass++;
        tick();
        n_total++;
        if (qdr_d_rise !== 18'h03333 || qdr_d_fall !== 18'h04444 || wr_done !== 1'b1)
            $display("FAIL midrst_post_pair23: rise=%h fall=%h done=%b, required 03333/04444/1",
                     qdr_d_rise, qdr_d_fall, wr_done);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_byte_enables();
        test_calibration();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
